// File: rtl/wb_arbiter_rr.sv
// Wishbone B3 N-to-1 arbiter with round-robin or fixed-priority selection,
// grant lock for the whole cyc, and a watchdog that forces err on hung accesses.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          grant_idx_q, grant_idx_d;
  logic [IW-1:0]          last_idx_q, last_idx_d;
  logic [WW-1:0]          wd_cnt_q, wd_cnt_d;

  logic                   grant_vld_s;
  logic [IW-1:0]          sel_idx_s;
  logic [NUM_MASTERS-1:0] sel_oh_s;
  logic                   g_cyc_s, g_stb_s;
  logic                   low_hit_s, rr_hit_s;
  logic [IW-1:0]          low_idx_s, rr_idx_s, arb_idx_s;
  logic                   rearb_s, grant_chg_s, term_s, wd_fire_s;

  assign grant_vld_s = (state_q == BUSY);
  // Idle routes master 0 so the slave-side don't-care outputs stay stable.
  assign sel_idx_s   = grant_vld_s ? grant_idx_q : {IW{1'b0}};
  assign term_s      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wd_fire_s   = (TIMEOUT != 0) && grant_vld_s && (wd_cnt_q == WW'(TIMEOUT));
  assign wbs_cyc_o   = grant_vld_s & g_cyc_s;
  assign wbs_stb_o   = grant_vld_s & g_stb_s & ~wd_fire_s;
  assign wbm_dat_o   = {NUM_MASTERS{wbs_dat_i}};

  always_comb begin
    wbs_adr_o = {AW{1'b0}};
    wbs_dat_o = {DW{1'b0}};
    wbs_sel_o = {SW{1'b0}};
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    wbs_we_o  = 1'b0;
    g_cyc_s   = 1'b0;
    g_stb_s   = 1'b0;
    sel_oh_s  = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_oh_s[i] = (sel_idx_s == i[IW-1:0]);
      wbs_adr_o   = wbs_adr_o | ({AW{sel_oh_s[i]}} & wbm_adr_i[i*AW +: AW]);
      wbs_dat_o   = wbs_dat_o | ({DW{sel_oh_s[i]}} & wbm_dat_i[i*DW +: DW]);
      wbs_sel_o   = wbs_sel_o | ({SW{sel_oh_s[i]}} & wbm_sel_i[i*SW +: SW]);
      wbs_cti_o   = wbs_cti_o | ({3{sel_oh_s[i]}} & wbm_cti_i[i*3 +: 3]);
      wbs_bte_o   = wbs_bte_o | ({2{sel_oh_s[i]}} & wbm_bte_i[i*2 +: 2]);
      wbs_we_o    = wbs_we_o | (sel_oh_s[i] & wbm_we_i[i]);
      g_cyc_s     = g_cyc_s | (sel_oh_s[i] & wbm_cyc_i[i]);
      g_stb_s     = g_stb_s | (sel_oh_s[i] & wbm_stb_i[i]);
    end
  end

  // Slave ack wins over a watchdog fire in the same cycle.
  always_comb begin
    grant_o   = {NUM_MASTERS{1'b0}};
    wbm_ack_o = {NUM_MASTERS{1'b0}};
    wbm_err_o = {NUM_MASTERS{1'b0}};
    wbm_rty_o = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_o[i]   = grant_vld_s & sel_oh_s[i];
      wbm_ack_o[i] = grant_o[i] & wbs_ack_i;
      wbm_err_o[i] = grant_o[i] & (wbs_err_i | (wd_fire_s & ~wbs_ack_i));
      wbm_rty_o[i] = grant_o[i] & wbs_rty_i;
    end
  end

  // Descending scan: the final hit is the lowest index overall / above last_idx.
  always_comb begin
    low_hit_s = 1'b0;
    rr_hit_s  = 1'b0;
    low_idx_s = {IW{1'b0}};
    rr_idx_s  = {IW{1'b0}};
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      low_hit_s = low_hit_s | wbm_cyc_i[i];
      low_idx_s = wbm_cyc_i[i] ? i[IW-1:0] : low_idx_s;
      rr_hit_s  = rr_hit_s | (wbm_cyc_i[i] && (i > int'(last_idx_q)));
      rr_idx_s  = (wbm_cyc_i[i] && (i > int'(last_idx_q))) ? i[IW-1:0] : rr_idx_s;
    end
    if ((RR_MODE != 0) && rr_hit_s) begin
      arb_idx_s = rr_idx_s;
    end else begin
      arb_idx_s = low_idx_s;
    end
  end

  // Next-state: re-arbitrate when idle or when the owner releases cyc.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    grant_chg_s = 1'b0;
    rearb_s     = 1'b1;
    case (state_q)
      IDLE:    rearb_s = 1'b1;
      BUSY:    rearb_s = ~g_cyc_s;
      default: rearb_s = 1'b1;
    endcase
    if (rearb_s && low_hit_s) begin
      state_d     = BUSY;
      grant_idx_d = arb_idx_s;
      last_idx_d  = (RR_MODE != 0) ? arb_idx_s : last_idx_q;
      grant_chg_s = 1'b1;
    end else if (rearb_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
    if ((TIMEOUT == 0) || !grant_vld_s || grant_chg_s || wd_fire_s || term_s || !g_stb_s) begin
      wd_cnt_d = {WW{1'b0}};
    end else begin
      wd_cnt_d = wd_cnt_q + WW'(1);
    end
  end

  // State registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      grant_idx_q <= {IW{1'b0}};
      last_idx_q  <= IW'(NUM_MASTERS - 1);
      wd_cnt_q    <= {WW{1'b0}};
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

endmodule
